tl_txn_tracker: RTL and testbench



---
 rtl/tl_txn_tracker_if.sv | 27 ++
 rtl/tl_txn_tracker.sv | 164 ++++++++++++++++
 tb/tb_tl_txn_tracker.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/tl_txn_tracker_if.sv
// TL-UL A/D channel handshake signals observed by the transaction tracker.
// The tracker drives only a_ready_o back toward the host.
interface tl_txn_tracker_if #(
  parameter int SourceW = 8
);
  logic               a_valid_i;
  logic               a_ready_i;
  logic               a_ready_o;
  logic [2:0]         a_opcode_i;
  logic [SourceW-1:0] a_source_i;
  logic               d_valid_i;
  logic               d_ready_i;
  logic [2:0]         d_opcode_i;
  logic [SourceW-1:0] d_source_i;

  modport master (
    output a_valid_i, a_ready_i, a_opcode_i, a_source_i,
    output d_valid_i, d_ready_i, d_opcode_i, d_source_i,
    input  a_ready_o
  );

  modport slave (
    input  a_valid_i, a_ready_i, a_opcode_i, a_source_i,
    input  d_valid_i, d_ready_i, d_opcode_i, d_source_i,
    output a_ready_o
  );
endinterface

// File: rtl/tl_txn_tracker.sv
// TL-UL outstanding-transaction tracker with protocol error detection.
// Define TL_TXN_TRACKER_LAT_EN to add per-entry age counters and max_lat_o.
module tl_txn_tracker #(
  parameter int SourceW = 8,
  parameter int Depth   = 4,
  parameter int Enforce = 1,
  localparam int CntW   = $clog2(Depth + 1),
  localparam int IdxW   = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic               clk,
  input  logic               rst,
  tl_txn_tracker_if.slave    bus,
  output logic [CntW-1:0]    outstanding_o,
  output logic               full_o,
  output logic               err_dup_o,
  output logic               err_unexp_o,
  output logic               err_opcode_o,
  output logic               err_ovf_o,
  output logic [15:0]        err_cnt_o,
  output logic [SourceW-1:0] last_err_src_o,
  output logic [15:0]        max_lat_o
);

  logic [Depth-1:0]   pend_q, pend_d, pend_free;
  logic [SourceW-1:0] src_q [Depth];
  logic [2:0]         exp_q [Depth];
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               dup_q, unexp_q, op_q, ovf_q;
  logic               dup_d, unexp_d, op_d, ovf_d;
  logic [15:0]        ecnt_q, ecnt_d;
  logic [SourceW-1:0] lsrc_q, lsrc_d;

  logic            a_hs, d_hs, d_hit, d_free;
  logic            a_legal, a_dup, f_ok, alloc;
  logic            a_err, d_err;
  logic [IdxW-1:0] d_idx, f_idx;
  logic [2:0]      npulse;
  logic [16:0]     esum;

  assign full_o = (cnt_q == CntW'(Depth));

  generate
    if (Enforce != 0) begin : g_enf
      assign bus.a_ready_o = bus.a_ready_i & ~full_o;
    end else begin : g_pas
      assign bus.a_ready_o = bus.a_ready_i;
    end
  endgenerate

  always_comb begin
    a_hs      = bus.a_valid_i & bus.a_ready_o;
    d_hs      = bus.d_valid_i & bus.d_ready_i;
    d_hit     = 1'b0;
    d_idx     = '0;
    for (int i = Depth - 1; i >= 0; i--) begin
      if (pend_q[i] && src_q[i] == bus.d_source_i) begin
        d_hit = 1'b1;
        d_idx = IdxW'(i);
      end
    end
    d_free    = d_hs & d_hit;
    pend_free = pend_q;
    if (d_free) pend_free[d_idx] = 1'b0;

    // Duplicate and free-slot checks see the table after this cycle's D free
    a_dup = 1'b0;
    f_ok  = 1'b0;
    f_idx = '0;
    for (int i = Depth - 1; i >= 0; i--) begin
      if (pend_free[i] && src_q[i] == bus.a_source_i) a_dup = 1'b1;
      if (!pend_free[i]) begin
        f_ok  = 1'b1;
        f_idx = IdxW'(i);
      end
    end
    a_legal = (bus.a_opcode_i == 3'd0) || (bus.a_opcode_i == 3'd1) ||
              (bus.a_opcode_i == 3'd4);

    dup_d   = a_hs & a_legal & a_dup;
    ovf_d   = a_hs & a_legal & ~a_dup & ~f_ok;
    alloc   = a_hs & a_legal & ~a_dup & f_ok;
    unexp_d = d_hs & ~d_hit;
    op_d    = (a_hs & ~a_legal) |
              (d_free & (exp_q[d_idx] != bus.d_opcode_i));

    pend_d = pend_free;
    if (alloc) pend_d[f_idx] = 1'b1;
    cnt_d = cnt_q + CntW'(alloc) - CntW'(d_free);

    npulse = 3'(dup_d) + 3'(unexp_d) + 3'(op_d) + 3'(ovf_d);
    esum   = {1'b0, ecnt_q} + 17'(npulse);
    ecnt_d = esum[16] ? 16'hFFFF : esum[15:0];

    d_err  = unexp_d | (d_free & (exp_q[d_idx] != bus.d_opcode_i));
    a_err  = dup_d | ovf_d | (a_hs & ~a_legal);
    lsrc_d = lsrc_q;
    if (d_err)      lsrc_d = bus.d_source_i;
    else if (a_err) lsrc_d = bus.a_source_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      cnt_q   <= '0;
      dup_q   <= 1'b0;
      unexp_q <= 1'b0;
      op_q    <= 1'b0;
      ovf_q   <= 1'b0;
      ecnt_q  <= '0;
      lsrc_q  <= '0;
    end else begin
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      dup_q   <= dup_d;
      unexp_q <= unexp_d;
      op_q    <= op_d;
      ovf_q   <= ovf_d;
      ecnt_q  <= ecnt_d;
      lsrc_q  <= lsrc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      src_q[f_idx] <= bus.a_source_i;
      exp_q[f_idx] <= (bus.a_opcode_i == 3'd4) ? 3'd1 : 3'd0;
    end
  end

`ifdef TL_TXN_TRACKER_LAT_EN
  logic [15:0] age_q [Depth];
  logic [15:0] max_q, lat;

  assign lat = (age_q[d_idx] == 16'hFFFF) ? 16'hFFFF : age_q[d_idx] + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
      for (int i = 0; i < Depth; i++) age_q[i] <= '0;
    end else begin
      if (d_free && lat > max_q) max_q <= lat;
      for (int i = 0; i < Depth; i++) begin
        if (alloc && f_idx == IdxW'(i))
          age_q[i] <= '0;
        else if (pend_q[i] && age_q[i] != 16'hFFFF)
          age_q[i] <= age_q[i] + 16'd1;
      end
    end
  end

  assign max_lat_o = max_q;
`else
  assign max_lat_o = '0;
`endif

  assign outstanding_o  = cnt_q;
  assign err_dup_o      = dup_q;
  assign err_unexp_o    = unexp_q;
  assign err_opcode_o   = op_q;
  assign err_ovf_o      = ovf_q;
  assign err_cnt_o      = ecnt_q;
  assign last_err_src_o = lsrc_q;

endmodule

// File: tb/tb_tl_txn_tracker.sv
// Scoreboard bench: directed steps queue expected outputs, a monitor compares.
// Two trackers: Depth=4/Enforce=1 and Depth=2/Enforce=0.
module tb_tl_txn_tracker;

`ifdef TL_TXN_TRACKER_LAT_EN
  localparam bit LAT = 1'b1;
`else
  localparam bit LAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tl_txn_tracker_if #(.SourceW(8)) bus0 ();
  tl_txn_tracker_if #(.SourceW(8)) bus1 ();

  logic [2:0]  o0;
  logic [1:0]  o1;
  logic        f0, f1;
  logic [3:0]  e0, e1;
  logic [15:0] c0, c1, m0, m1;
  logic [7:0]  s0, s1;

  tl_txn_tracker #(.SourceW(8), .Depth(4), .Enforce(1)) u0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .outstanding_o(o0), .full_o(f0),
    .err_dup_o(e0[3]), .err_unexp_o(e0[2]),
    .err_opcode_o(e0[1]), .err_ovf_o(e0[0]),
    .err_cnt_o(c0), .last_err_src_o(s0), .max_lat_o(m0)
  );

  tl_txn_tracker #(.SourceW(8), .Depth(2), .Enforce(0)) u1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .outstanding_o(o1), .full_o(f1),
    .err_dup_o(e1[3]), .err_unexp_o(e1[2]),
    .err_opcode_o(e1[1]), .err_ovf_o(e1[0]),
    .err_cnt_o(c1), .last_err_src_o(s1), .max_lat_o(m1)
  );

  typedef struct {
    string name;
    int    dut;
    int    outst;
    bit    full;
    bit    ardy;
    bit [3:0] err;
    int    cnt;
    int    lsrc;
    int    mlat;
  } exp_t;

  exp_t q[$];
  int nchk = 0;
  int nerr = 0;
  int sel = 0;
  bit rst_v = 1'b1;

  task automatic chk(string n, string f, logic [31:0] got, logic [31:0] ex);
    nchk++;
    if (got !== ex) begin
      nerr++;
      $display("FAIL %s.%s: got %0h expected %0h", n, f, got, ex);
    end
  endtask

  task automatic step(string n, bit av, logic [2:0] aop, logic [7:0] as,
                      bit dv, logic [2:0] dop, logic [7:0] ds,
                      int o, bit [3:0] e, int c, int ls, int ml);
    exp_t x;
    @(negedge clk);
    rst = rst_v;
    if (sel == 0) begin
      bus0.a_valid_i = av; bus0.a_opcode_i = aop; bus0.a_source_i = as;
      bus0.d_valid_i = dv; bus0.d_opcode_i = dop; bus0.d_source_i = ds;
    end else begin
      bus1.a_valid_i = av; bus1.a_opcode_i = aop; bus1.a_source_i = as;
      bus1.d_valid_i = dv; bus1.d_opcode_i = dop; bus1.d_source_i = ds;
    end
    x.name  = n;
    x.dut   = sel;
    x.outst = o;
    x.full  = (sel == 0) ? (o == 4) : (o == 2);
    x.ardy  = (sel == 0) ? (o != 4) : 1'b1;
    x.err   = e;
    x.cnt   = c;
    x.lsrc  = ls;
    x.mlat  = LAT ? ml : 0;
    q.push_back(x);
  endtask

  task automatic idle(string n, int o, bit [3:0] e, int c, int ls, int ml);
    step(n, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, o, e, c, ls, ml);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        x = q.pop_front();
        if (x.dut == 0) begin
          chk(x.name, "outstanding", 32'(o0), 32'(x.outst));
          chk(x.name, "full", 32'(f0), 32'(x.full));
          chk(x.name, "a_ready", 32'(bus0.a_ready_o), 32'(x.ardy));
          chk(x.name, "err", 32'(e0), 32'(x.err));
          chk(x.name, "err_cnt", 32'(c0), 32'(x.cnt));
          chk(x.name, "last_src", 32'(s0), 32'(x.lsrc));
          chk(x.name, "max_lat", 32'(m0), 32'(x.mlat));
        end else begin
          chk(x.name, "outstanding", 32'(o1), 32'(x.outst));
          chk(x.name, "full", 32'(f1), 32'(x.full));
          chk(x.name, "a_ready", 32'(bus1.a_ready_o), 32'(x.ardy));
          chk(x.name, "err", 32'(e1), 32'(x.err));
          chk(x.name, "err_cnt", 32'(c1), 32'(x.cnt));
          chk(x.name, "last_src", 32'(s1), 32'(x.lsrc));
          chk(x.name, "max_lat", 32'(m1), 32'(x.mlat));
        end
      end
    end
  end

  initial begin
    bus0.a_valid_i = 0; bus0.a_ready_i = 1; bus0.a_opcode_i = 0;
    bus0.a_source_i = 0; bus0.d_valid_i = 0; bus0.d_ready_i = 1;
    bus0.d_opcode_i = 0; bus0.d_source_i = 0;
    bus1.a_valid_i = 0; bus1.a_ready_i = 1; bus1.a_opcode_i = 0;
    bus1.a_source_i = 0; bus1.d_valid_i = 0; bus1.d_ready_i = 1;
    bus1.d_opcode_i = 0; bus1.d_source_i = 0;

    sel = 0;
    rst_v = 1;
    idle("rst0a", 0, 4'b0000, 0, 0, 0);
    idle("rst0b", 0, 4'b0000, 0, 0, 0);
    rst_v = 0;
    step("get5", 1, 3'd4, 8'h05, 0, 3'd0, 8'h00, 1, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 6; i++) idle("wait5", 1, 4'b0000, 0, 0, 0);
    step("ack5", 0, 3'd0, 8'h00, 1, 3'd1, 8'h05, 0, 4'b0000, 0, 0, 7);
    step("put9a", 1, 3'd0, 8'h09, 0, 3'd0, 8'h00, 1, 4'b0000, 0, 0, 7);
    step("put9b", 1, 3'd0, 8'h09, 0, 3'd0, 8'h00, 1, 4'b1000, 1, 9, 7);
    idle("dupclr", 1, 4'b0000, 1, 9, 7);
    step("ack9", 0, 3'd0, 8'h00, 1, 3'd0, 8'h09, 0, 4'b0000, 1, 9, 7);
    step("unexp33", 0, 3'd0, 8'h00, 1, 3'd0, 8'h33, 0, 4'b0100, 2, 'h33, 7);
    step("get7", 1, 3'd4, 8'h07, 0, 3'd0, 8'h00, 1, 4'b0000, 2, 'h33, 7);
    step("badop7", 0, 3'd0, 8'h00, 1, 3'd0, 8'h07, 0, 4'b0010, 3, 7, 7);
    step("aop2", 1, 3'd2, 8'h11, 0, 3'd0, 8'h00, 0, 4'b0010, 4, 'h11, 7);
    step("get1", 1, 3'd4, 8'h01, 0, 3'd0, 8'h00, 1, 4'b0000, 4, 'h11, 7);
    step("get2", 1, 3'd4, 8'h02, 0, 3'd0, 8'h00, 2, 4'b0000, 4, 'h11, 7);
    step("get3", 1, 3'd4, 8'h03, 0, 3'd0, 8'h00, 3, 4'b0000, 4, 'h11, 7);
    step("get4", 1, 3'd4, 8'h04, 0, 3'd0, 8'h00, 4, 4'b0000, 4, 'h11, 7);
    step("blocked", 1, 3'd4, 8'h05, 0, 3'd0, 8'h00, 4, 4'b0000, 4, 'h11, 7);
    step("ack2", 0, 3'd0, 8'h00, 1, 3'd1, 8'h02, 3, 4'b0000, 4, 'h11, 7);
    step("swap3", 1, 3'd4, 8'h03, 1, 3'd1, 8'h03, 3, 4'b0000, 4, 'h11, 7);
    step("dual", 1, 3'd4, 8'h01, 1, 3'd1, 8'h40, 3, 4'b1100, 6, 'h40, 7);
    idle("dualclr", 3, 4'b0000, 6, 'h40, 7);
    rst_v = 1;
    idle("midrst", 0, 4'b0000, 0, 0, 0);
    rst_v = 0;
    step("stale1", 0, 3'd0, 8'h00, 1, 3'd1, 8'h01, 0, 4'b0100, 1, 1, 0);
    idle("end0", 0, 4'b0000, 1, 1, 0);

    sel = 1;
    rst_v = 1;
    idle("rst1", 0, 4'b0000, 0, 0, 0);
    rst_v = 0;
    step("p_get1", 1, 3'd4, 8'h01, 0, 3'd0, 8'h00, 1, 4'b0000, 0, 0, 0);
    step("p_get2", 1, 3'd4, 8'h02, 0, 3'd0, 8'h00, 2, 4'b0000, 0, 0, 0);
    step("p_get3", 1, 3'd4, 8'h03, 0, 3'd0, 8'h00, 2, 4'b0001, 1, 3, 0);
    step("p_swap1", 1, 3'd4, 8'h01, 1, 3'd1, 8'h01, 2, 4'b0000, 1, 3, 3);
    idle("end1", 2, 4'b0000, 1, 3, 3);

    repeat (4) @(posedge clk);
    #3;
    nchk++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
